// File: rtl/seq_scan_if.sv
// Word-in / result-out handshake bundle for seq_scan_ctrl, plus the detector observation taps.
// slave is the controller side; master is the producer/consumer side.
interface seq_scan_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4,
   parameter int unsigned IDX_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_count;
   logic             out_hit;
   logic [IDX_W-1:0] out_first;
   logic             det_bit;
   logic             det_out;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_count, out_hit, out_first, det_bit, det_out
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_count, out_hit, out_first, det_bit, det_out
   );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serialises each accepted word MSB-first into a run detector and reports hit count / first index.
// Define SEQ_SCAN_CARRY_EN to let runs continue across consecutive words (only reset clears them).
module seq_scan_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned RUN_LEN = 4,
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned IDX_W   = 3
) (
   input logic       clk,
   input logic       reset,
   seq_scan_if.slave bus
);
   localparam int unsigned RunW = $clog2(RUN_LEN + 1);
   localparam logic [RunW-1:0]  RunMax  = RunW'(RUN_LEN);
   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [IDX_W-1:0] idx_q;
   logic [RunW-1:0]  run_q;
   logic [RunW-1:0]  run_d;
   logic             last_q;
   logic [CNT_W-1:0] count_q;
   logic [IDX_W-1:0] first_q;
   logic             hit_q;
   logic             out_valid_q;
   logic             cur_bit;

   assign cur_bit = shift_q[WIDTH-1];

   // Run length saturates at RUN_LEN so every further equal bit re-hits.
   always_comb begin
      run_d = RunW'(1);
      if (run_q != '0 && cur_bit == last_q) begin
         run_d = (run_q == RunMax) ? RunMax : run_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         idx_q       <= '0;
         run_q       <= '0;
         last_q      <= 1'b0;
         count_q     <= '0;
         first_q     <= '0;
         hit_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  shift_q <= bus.in_data;
                  idx_q   <= '0;
                  count_q <= '0;
                  first_q <= '0;
                  hit_q   <= 1'b0;
`ifdef SEQ_SCAN_CARRY_EN
                  // Run state deliberately survives the word boundary.
`else
                  run_q   <= '0;
                  last_q  <= 1'b0;
`endif
                  state_q <= StScan;
               end
            end
            StScan: begin
               shift_q <= shift_q << 1;
               run_q   <= run_d;
               last_q  <= cur_bit;
               idx_q   <= idx_q + 1'b1;
               if (run_d == RunMax) begin
                  if (count_q != CntMax) begin
                     count_q <= count_q + 1'b1;
                  end
                  if (!hit_q) begin
                     first_q <= idx_q;
                     hit_q   <= 1'b1;
                  end
               end
               if (idx_q == IdxLast) begin
                  state_q     <= StDone;
                  out_valid_q <= 1'b1;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.out_count = count_q;
   assign bus.out_hit   = hit_q;
   assign bus.out_first = first_q;
   assign bus.det_bit   = (state_q == StScan) & cur_bit;
   assign bus.det_out   = (run_q == RunMax);
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed words plus random words against a run-length model.
// The model tracks the unbounded length of the current equal-bit run; a bit is a hit when it is >= RUN_LEN.
module tb_seq_scan_ctrl;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned RUN_LEN = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned IDX_W   = 3;
`ifdef SEQ_SCAN_CARRY_EN
   localparam bit Carry = 1'b1;
`else
   localparam bit Carry = 1'b0;
`endif
   // 8'hC0 after 8'h03: carried "11" run extends into the new word
   localparam int ExpC0Cnt   = Carry ? 4 : 3;
   localparam int ExpC0First = Carry ? 1 : 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_scan_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

   seq_scan_ctrl #(.WIDTH(WIDTH), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int m_len  = 0;
   bit m_last = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      m_len  = 0;
      m_last = 1'b0;
   endtask

   // Sends one word, checks every scan cycle and the result, holds DONE for 'hold' cycles.
   task automatic scan_word(input logic [WIDTH-1:0] data, input int hold, input bit noisy,
                            output int cnt_o, output int first_o);
      int cnt;
      int first;
      bit hit;
      bit b;
      int waited;
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_wait: got %b want 1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      step();
      bus.in_valid = 1'b0;
      if (!Carry) m_len = 0;
      cnt = 0; first = 0; hit = 1'b0;
      for (int k = 0; k < int'(WIDTH); k++) begin
         b = data[WIDTH-1-k];
         checks++;
         if (bus.det_bit !== b || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL scan[%0d] data=%h: det_bit/out_valid/in_ready got %b%b%b want %b00",
                     k, data, bus.det_bit, bus.out_valid, bus.in_ready, b);
         end
         if (m_len > 0 && b == m_last) m_len++;
         else begin
            m_len  = 1;
            m_last = b;
         end
         if (m_len >= int'(RUN_LEN)) begin
            if (cnt < (1 << CNT_W) - 1) cnt++;
            if (!hit) begin
               hit   = 1'b1;
               first = k;
            end
         end
         if (noisy) begin
            bus.out_ready = (k == int'(WIDTH) - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = WIDTH'($urandom);
         end
         step();
         checks++;
         if (bus.det_out !== (m_len >= int'(RUN_LEN))) begin
            errors++;
            $display("FAIL det_out after idx %0d data=%h: got %b want %b",
                     k, data, bus.det_out, (m_len >= int'(RUN_LEN)));
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_count !== CNT_W'(cnt) || bus.out_hit !== hit ||
          bus.out_first !== IDX_W'(first)) begin
         errors++;
         $display("FAIL result data=%h: valid/count/hit/first got %b/%0d/%b/%0d want 1/%0d/%b/%0d",
                  data, bus.out_valid, bus.out_count, bus.out_hit, bus.out_first, cnt, hit, first);
      end
      cnt_o   = int'(bus.out_count);
      first_o = int'(bus.out_first);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = (h % 2 == 1);
         bus.in_data  = ~data;
         step();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_count !== CNT_W'(cnt) ||
             bus.out_first !== IDX_W'(first) || bus.out_hit !== hit) begin
            errors++;
            $display("FAIL hold[%0d] data=%h: valid/ready/count/first got %b/%b/%0d/%0d want 1/0/%0d/%0d",
                     h, data, bus.out_valid, bus.in_ready, bus.out_count, bus.out_first, cnt, first);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release data=%h: out_valid/in_ready got %b/%b want 0/1",
                  data, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset = 1'b0;
      step();
      step();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.det_out !== 1'b0 ||
          bus.det_bit !== 1'b0 || bus.out_count !== '0 || bus.out_hit !== 1'b0 ||
          bus.out_first !== '0) begin
         errors++;
         $display("FAIL reset_state: rdy/vld/dout/dbit/cnt/hit/first got %b/%b/%b/%b/%0d/%b/%0d want 1/0/0/0/0/0/0",
                  bus.in_ready, bus.out_valid, bus.det_out, bus.det_bit, bus.out_count,
                  bus.out_hit, bus.out_first);
      end
      reset = 1'b1;
      m_len = 0;
   endtask

   task automatic test_basic();
      int c, f;
      do_reset();
      scan_word(8'h00, 0, 1'b0, c, f);
      checks++;
      if (c != 5 || f != 3) begin
         errors++;
         $display("FAIL word_00: count/first got %0d/%0d want 5/3", c, f);
      end
      scan_word(8'hF0, 0, 1'b0, c, f);
      checks++;
      if (c != 2 || f != 3) begin
         errors++;
         $display("FAIL word_F0: count/first got %0d/%0d want 2/3", c, f);
      end
      scan_word(8'hAA, 0, 1'b0, c, f);
      checks++;
      if (c != 0 || f != 0) begin
         errors++;
         $display("FAIL word_AA: count/first got %0d/%0d want 0/0", c, f);
      end
   endtask

   task automatic test_backpressure();
      int c, f;
      do_reset();
      scan_word(8'h0F, 5, 1'b0, c, f);
      checks++;
      if (c != 2 || f != 3) begin
         errors++;
         $display("FAIL backpressure_0F: count/first got %0d/%0d want 2/3", c, f);
      end
   endtask

   task automatic test_back_to_back();
      int c, f;
      do_reset();
      // six leading zeros: hits at 3, 4, 5
      scan_word(8'h03, 0, 1'b0, c, f);
      checks++;
      if (c != 3 || f != 3) begin
         errors++;
         $display("FAIL word_03: count/first got %0d/%0d want 3/3", c, f);
      end
      scan_word(8'hC0, 0, 1'b0, c, f);
      checks++;
      if (c != ExpC0Cnt || f != ExpC0First) begin
         errors++;
         $display("FAIL word_C0: count/first got %0d/%0d want %0d/%0d", c, f, ExpC0Cnt, ExpC0First);
      end
   endtask

   task automatic test_reset_abort();
      int c, f;
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.det_out !== 1'b0 ||
          bus.det_bit !== 1'b0) begin
         errors++;
         $display("FAIL abort: out_valid/in_ready/det_out/det_bit got %b/%b/%b/%b want 0/1/0/0",
                  bus.out_valid, bus.in_ready, bus.det_out, bus.det_bit);
      end
      m_len = 0;
      step();
      step();
      reset = 1'b1;
      scan_word(8'h0F, 0, 1'b0, c, f);
      checks++;
      if (c != 2 || f != 3) begin
         errors++;
         $display("FAIL after_abort_0F: count/first got %0d/%0d want 2/3", c, f);
      end
   endtask

   task automatic test_random();
      int c, f;
      logic [WIDTH-1:0] d;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         d = WIDTH'($urandom);
         case ($urandom_range(0, 3))
            0: d = d & 8'hF0;
            1: d = d | 8'h0F;
            default: ;
         endcase
         scan_word(d, int'($urandom_range(0, 3)), 1'b1, c, f);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
